// File: rtl/data_ram_resp_if.sv
// Memory-stage access port between the pipeline's memory stage and the data RAM responder.
interface data_ram_resp_if;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ack_o;
  logic        mem_err_o;
  logic        mem_busy_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, mem_ack_o, mem_err_o, mem_busy_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, mem_ack_o, mem_err_o, mem_busy_o
  );
endinterface

// File: rtl/data_ram_resp.sv
// Data-memory responder: accepts one request, inserts WAIT_CYCLES wait states,
// then performs the access on a word-organised big-endian RAM and pulses ack or err.
module data_ram_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  data_ram_resp_if.slave bus
);

  localparam int         AddrW    = DEPTH_LOG2 + 2;
  localparam int         Depth    = 1 << DEPTH_LOG2;
  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [AddrW-1:0]     addr_q;
  logic                 we_q;
  logic [3:0]           sel_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  logic                 ack_q;
  logic                 err_q;
  logic [31:0]          ram [Depth];

  logic                 accept;
  logic                 enterResp;
  logic                 misaligned;
  logic                 doWrite;
  logic [AddrW-1:0]     accAddr;
  logic                 accWe;
  logic [3:0]           accSel;
  logic [31:0]          accData;
  logic [DEPTH_LOG2-1:0] wordIdx;

  assign accept    = (state_q == ST_IDLE) && bus.mem_ce_i;
  assign enterResp = (state_d == ST_RESP);
  assign wordIdx   = accAddr[AddrW-1:2];
  assign doWrite   = enterResp && accWe && !misaligned;

  // With zero wait states the access happens on the accepting edge, so take the live request in IDLE
  always_comb begin
    accAddr = addr_q;
    accWe   = we_q;
    accSel  = sel_q;
    accData = wdata_q;
    if (state_q == ST_IDLE) begin
      accAddr = bus.mem_addr_i[AddrW-1:0];
      accWe   = bus.mem_we_i;
      accSel  = bus.mem_sel_i;
      accData = bus.mem_data_i;
    end
  end

  // Full words need 4-byte alignment, halfwords need 2-byte alignment; other selects always pass
  always_comb begin
    misaligned = 1'b0;
    if (accSel == 4'b1111 && accAddr[1:0] != 2'b00) begin
      misaligned = 1'b1;
    end
    if ((accSel == 4'b1100 || accSel == 4'b0011) && accAddr[0]) begin
      misaligned = 1'b1;
    end
  end

  // State register and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: count down wait states, RESP lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_ce_i) begin
          cnt_d   = WaitInit;
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stall the pipeline from the request cycle through the last wait state
  always_comb begin
    bus.mem_busy_o = ((state_q == ST_IDLE) && bus.mem_ce_i) || (state_q == ST_WAIT);
  end

  // Capture the request on acceptance so the requester may change its inputs afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'b0000;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= bus.mem_addr_i[AddrW-1:0];
      we_q    <= bus.mem_we_i;
      sel_q   <= bus.mem_sel_i;
      wdata_q <= bus.mem_data_i;
    end
  end

  // Response registers: one-cycle ack/err pulse, read data only on a good read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= enterResp && !misaligned;
      err_q   <= enterResp && misaligned;
      rdata_q <= (enterResp && !accWe && !misaligned) ? ram[wordIdx] : '0;
    end
  end

  // RAM byte-lane write; lane 3 is the lowest byte address; reset blocks any pending write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
    end else if (doWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (accSel[b]) begin
          ram[wordIdx][8*b +: 8] <= accData[8*b +: 8];
        end
      end
    end
  end

  assign bus.mem_data_o = rdata_q;
  assign bus.mem_ack_o  = ack_q;
  assign bus.mem_err_o  = err_q;

endmodule
